stage_sequencer: RTL and testbench

// Parametrised master sequencer for the camera/vision pipeline. Drives N processing

---
 rtl/stage_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_stage_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// stage_sequencer
//   Master sequencer for the camera/vision pipeline. Walks the enabled stages
//   in index order through a start/done/ack handshake. It supports one-shot and
//   continuous passes, a per-handshake timeout, error capture, per-stage
//   result-latch strobes and a pass counter.
//
// Handshake (per stage i, only the active stage is ever addressed):
//   stage_start[i] rises and stays high until the FSM sees stage_done[i].
//   latch_en[i] then pulses for one cycle. After that, stage_ack[i] is held
//   high until the stage drops stage_done[i].
//
// Ports
//   clk            pipeline clock
//   reset          asynchronous, active-low reset
//   enable         allow passes to start / continue
//   mode           0 = one-shot, 1 = continuous
//   stage_mask     participating stages, sampled at pass start
//   timeout_cycles max cycles per handshake phase, 0 = no timeout
//   clear_err      leave ERROR
//   stage_done     done level from each stage, held until ack
//   stage_error    error level from each stage
//   stage_start    start to the active stage
//   stage_ack      ack to the active stage
//   latch_en       one-cycle strobe to capture the active stage's results
//   busy           FSM is neither IDLE nor ERROR
//   cur_stage      index of the active stage
//   state_dbg      encoded FSM state
//   err_flag       high while in ERROR
//   err_stage      stage that caused the last error
//   err_code       01 = stage error, 10 = timeout, 00 = none
//   pass_count     completed passes (wrapping)
module stage_sequencer #(
  parameter int N_STAGES  = 2,
  parameter int IDX_W     = 3,
  parameter int TIMEOUT_W = 24,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 mode,
  input  logic [N_STAGES-1:0]  stage_mask,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic                 clear_err,
  input  logic [N_STAGES-1:0]  stage_done,
  input  logic [N_STAGES-1:0]  stage_error,
  output logic [N_STAGES-1:0]  stage_start,
  output logic [N_STAGES-1:0]  stage_ack,
  output logic [N_STAGES-1:0]  latch_en,
  output logic                 busy,
  output logic [IDX_W-1:0]     cur_stage,
  output logic [3:0]           state_dbg,
  output logic                 err_flag,
  output logic [IDX_W-1:0]     err_stage,
  output logic [1:0]           err_code,
  output logic [CNT_W-1:0]     pass_count
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_EXEC     = 3'd2;
  localparam logic [2:0] S_DONE     = 3'd3;
  localparam logic [2:0] S_ACK      = 3'd4;
  localparam logic [2:0] S_ACK_WAIT = 3'd5;
  localparam logic [2:0] S_NEXT     = 3'd6;
  localparam logic [2:0] S_ERROR    = 3'd7;

  logic [2:0]           state, state_nxt;
  logic [N_STAGES-1:0]  mask_q, mask_nxt;
  logic [IDX_W-1:0]     cur_nxt;
  logic [TIMEOUT_W-1:0] timer;
  logic                 timer_clr;
  logic                 pass_inc;
  logic                 err_set, err_clr;
  logic [1:0]           err_code_nxt;

  logic [N_STAGES-1:0]  cur_onehot;
  logic [IDX_W-1:0]     low_idx;     // lowest set bit of stage_mask
  logic [IDX_W-1:0]     above_idx;   // next set bit of mask_q above cur_stage
  logic                 above_found;
  logic                 cur_done, cur_err, timer_hit;

  // The loop runs downward so the last hit is the lowest qualifying index.
  always_comb begin
    cur_onehot  = '0;
    low_idx     = '0;
    above_idx   = '0;
    above_found = 1'b0;
    for (int i = N_STAGES - 1; i >= 0; i--) begin
      cur_onehot[i] = (cur_stage == IDX_W'(i));
      if (stage_mask[i]) low_idx = IDX_W'(i);
      if (mask_q[i] && (IDX_W'(i) > cur_stage)) begin
        above_idx   = IDX_W'(i);
        above_found = 1'b1;
      end
    end
  end

  // Inputs of inactive stages are masked off here, so they can never steer the FSM.
  assign cur_done = |(stage_done & cur_onehot);
  assign cur_err  = |(stage_error & cur_onehot);

  // The timer is cleared on entry to a phase and reads k-1 in the k-th cycle
  // of that phase. The phase therefore ends after exactly timeout_cycles cycles.
  assign timer_hit = (timeout_cycles != '0) &&
                     (timer == (timeout_cycles - TIMEOUT_W'(1)));

  always_comb begin
    state_nxt    = state;
    mask_nxt     = mask_q;
    cur_nxt      = cur_stage;
    timer_clr    = 1'b0;
    pass_inc     = 1'b0;
    err_set      = 1'b0;
    err_clr      = 1'b0;
    err_code_nxt = 2'b00;
    case (state)
      S_IDLE: begin
        if (enable && (|stage_mask)) begin
          mask_nxt  = stage_mask;
          cur_nxt   = low_idx;
          state_nxt = S_START;
        end
      end
      S_START: begin
        timer_clr = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (cur_err) begin
          err_set      = 1'b1;
          err_code_nxt = 2'b01;
          state_nxt    = S_ERROR;
        end else if (cur_done) begin
          state_nxt = S_DONE;
        end else if (timer_hit) begin
          err_set      = 1'b1;
          err_code_nxt = 2'b10;
          state_nxt    = S_ERROR;
        end
      end
      S_DONE: state_nxt = S_ACK;
      S_ACK: begin
        timer_clr = 1'b1;
        state_nxt = S_ACK_WAIT;
      end
      S_ACK_WAIT: begin
        if (!cur_done) begin
          state_nxt = S_NEXT;
        end else if (timer_hit) begin
          err_set      = 1'b1;
          err_code_nxt = 2'b10;
          state_nxt    = S_ERROR;
        end
      end
      S_NEXT: begin
        if (above_found) begin
          cur_nxt   = above_idx;
          state_nxt = S_START;
        end else begin
          pass_inc = 1'b1;
          // enable is only consulted at the pass boundary; dropping it mid-pass
          // lets the pass finish.
          if (mode && enable && (|stage_mask)) begin
            mask_nxt  = stage_mask;
            cur_nxt   = low_idx;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_ERROR: begin
        if (clear_err) begin
          err_clr   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      mask_q     <= '0;
      cur_stage  <= '0;
      timer      <= '0;
      pass_count <= '0;
      err_stage  <= '0;
      err_code   <= 2'b00;
    end else begin
      state     <= state_nxt;
      mask_q    <= mask_nxt;
      cur_stage <= cur_nxt;
      if (timer_clr) begin
        timer <= '0;
      end else if (((state == S_EXEC) || (state == S_ACK_WAIT)) && (timer != '1)) begin
        timer <= timer + TIMEOUT_W'(1);
      end
      if (pass_inc) pass_count <= pass_count + CNT_W'(1);
      if (err_set) begin
        err_stage <= cur_stage;
        err_code  <= err_code_nxt;
      end else if (err_clr) begin
        err_code <= 2'b00;
      end
    end
  end

  // Moore outputs decoded from the registered state only, so they fall with reset.
  assign stage_start = ((state == S_START) || (state == S_EXEC)) ? cur_onehot : '0;
  assign stage_ack   = ((state == S_ACK) || (state == S_ACK_WAIT)) ? cur_onehot : '0;
  assign latch_en    = (state == S_DONE) ? cur_onehot : '0;
  assign busy        = (state != S_IDLE) && (state != S_ERROR);
  assign err_flag    = (state == S_ERROR);
  assign state_dbg   = {1'b0, state};

endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer
//   Bench for stage_sequencer with two stages. A stage responder raises done or
//   error a configurable number of start cycles after start is first seen, and
//   drops done a configurable number of cycles after ack. The expected latch
//   order is pushed when each pass is launched and popped as latch_en strobes.
module tb_stage_sequencer;
  localparam int N     = 2;
  localparam int IDX_W = 3;
  localparam int TW    = 24;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          mode = 1'b0;
  logic          clear_err = 1'b0;
  logic [N-1:0]  stage_mask = '0;
  logic [N-1:0]  stage_done = '0;
  logic [N-1:0]  stage_error = '0;
  logic [TW-1:0] timeout_cycles = '0;
  logic [N-1:0]  stage_start, stage_ack, latch_en;
  logic          busy, err_flag;
  logic [IDX_W-1:0] cur_stage, err_stage;
  logic [3:0]    state_dbg;
  logic [1:0]    err_code;
  logic [CW-1:0] pass_count;

  int checks = 0;
  int errors = 0;
  logic [IDX_W-1:0] exp_q[$];
  int done_delay[N];
  bit hang[N];
  bit err_cfg[N];
  int ack_hold[N];
  int exp_pass = 0;
  int start0_cnt = 0;

  stage_sequencer #(.N_STAGES(N), .IDX_W(IDX_W), .TIMEOUT_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .stage_mask(stage_mask), .timeout_cycles(timeout_cycles), .clear_err(clear_err),
    .stage_done(stage_done), .stage_error(stage_error),
    .stage_start(stage_start), .stage_ack(stage_ack), .latch_en(latch_en),
    .busy(busy), .cur_stage(cur_stage), .state_dbg(state_dbg),
    .err_flag(err_flag), .err_stage(err_stage), .err_code(err_code),
    .pass_count(pass_count)
  );

  // ---------------- clock ----------------
  always #20 clk = ~clk;

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = '0;
    for (int i = 0; i < N; i++) if (idx == IDX_W'(i)) onehot[i] = 1'b1;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    idx_of = 0;
    for (int i = 0; i < N; i++) if (v[i]) idx_of = i;
  endfunction

  // ---------------- stage responder ----------------
  initial begin : responder
    int cnt[N];
    int acnt[N];
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!reset || err_flag) begin
          stage_done[i]  = 1'b0;
          stage_error[i] = 1'b0;
          cnt[i]  = 0;
          acnt[i] = 0;
        end else begin
          if (stage_start[i]) begin
            cnt[i]++;
            if (cnt[i] == done_delay[i]) begin
              if (!hang[i])   stage_done[i]  = 1'b1;
              if (err_cfg[i]) stage_error[i] = 1'b1;
            end
          end else begin
            cnt[i] = 0;
          end
          if (stage_ack[i]) begin
            acnt[i]++;
            if (acnt[i] >= ack_hold[i]) stage_done[i] = 1'b0;
          end else begin
            acnt[i] = 0;
          end
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [N-1:0] prev_ds, prev_lat;
    logic prev_err, prev_s0;
    prev_ds = '0; prev_lat = '0; prev_err = 1'b0; prev_s0 = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        prev_ds = '0; prev_lat = '0; prev_err = 1'b0; prev_s0 = 1'b0;
      end else begin
        if ((prev_ds != '0) && !prev_err) check("latch_latency", 32'(latch_en), 32'(prev_ds));
        if (prev_lat != '0) check("ack_latency", 32'(stage_ack), 32'(prev_lat));
        if (stage_start != '0) check("start_onehot", 32'(stage_start), 32'(onehot(cur_stage)));
        if (stage_ack != '0)   check("ack_onehot", 32'(stage_ack), 32'(onehot(cur_stage)));
        if (latch_en != '0) begin
          check("latch_onehot", 32'(latch_en), 32'(onehot(cur_stage)));
          if (exp_q.size() == 0) check("sb_unexpected_latch", 32'(latch_en), 0);
          else check("sb_latch_stage", 32'(idx_of(latch_en)), 32'(exp_q.pop_front()));
        end
        if (stage_start[0] && !prev_s0) start0_cnt++;
        prev_s0  = stage_start[0];
        prev_ds  = stage_done & stage_start;
        prev_err = |(stage_error & stage_start);
        prev_lat = latch_en;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy) check({tag, "_idle_timeout"}, 32'(busy), 0);
  endtask

  task automatic wait_err(input string tag);
    int n = 0;
    while (!err_flag && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_err_flag"}, 32'(err_flag), 1);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int n, cnt, s0;
    bit idle_seen;
    done_delay = '{5, 8};
    hang       = '{0, 0};
    err_cfg    = '{0, 0};
    ack_hold   = '{1, 1};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_start", 32'(stage_start), 0);
    check("rst_ack", 32'(stage_ack), 0);
    check("rst_latch", 32'(latch_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_state", 32'(state_dbg), 0);
    check("rst_err_code", 32'(err_code), 0);
    check("rst_pass", 32'(pass_count), 0);
    reset = 1'b1;
    @(negedge clk);

    // one-shot, both stages, done after 5 and 8 cycles
    stage_mask = 2'b11; mode = 1'b0; done_delay = '{5, 8};
    exp_q.push_back(IDX_W'(0)); exp_q.push_back(IDX_W'(1));
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    check("t1_first_start", 32'(stage_start), 1);
    check("t1_first_cur", 32'(cur_stage), 0);
    check("t1_start_state", 32'(state_dbg), 1);
    wait_idle("t1");
    exp_pass++;
    #2;
    check("t1_pass_count", 32'(pass_count), 32'(exp_pass));
    check("t1_state_idle", 32'(state_dbg), 0);
    check("t1_sb_drained", 32'(exp_q.size()), 0);

    // mask 10, continuous: stage 0 never started, back-to-back passes
    @(negedge clk);
    stage_mask = 2'b10; mode = 1'b1; done_delay = '{5, 4};
    s0 = start0_cnt;
    for (int k = 0; k < 4; k++) exp_q.push_back(IDX_W'(1));
    enable = 1'b1;
    @(negedge clk);
    check("t2_first_cur", 32'(cur_stage), 1);
    check("t2_first_start", 32'(stage_start), 2);
    n = 0; idle_seen = 1'b0;
    while ((pass_count != CW'(exp_pass + 3)) && n < 3000) begin
      @(negedge clk);
      n++;
      if (!busy) idle_seen = 1'b1;
    end
    enable = 1'b0;
    check("t2_three_passes", 32'(pass_count), 32'(exp_pass + 3));
    check("t2_back_to_back", 32'(idle_seen), 0);
    exp_pass += 3;
    wait_idle("t2");
    exp_pass++;
    #2;
    check("t2_pass_count", 32'(pass_count), 32'(exp_pass));
    check("t2_stage0_never_started", 32'(start0_cnt - s0), 0);

    // timeout of 10 with stage 0 never done
    @(negedge clk);
    stage_mask = 2'b01; mode = 1'b0; timeout_cycles = TW'(10); hang[0] = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    n = 0; cnt = 0;
    while (!err_flag && n < 200) begin
      if (stage_start[0]) cnt++;
      @(negedge clk);
      n++;
    end
    check("t3_err_flag", 32'(err_flag), 1);
    check("t3_start_cycles", 32'(cnt), 11);
    check("t3_err_code", 32'(err_code), 2);
    check("t3_err_stage", 32'(err_stage), 0);
    check("t3_start_low", 32'(stage_start), 0);
    check("t3_busy", 32'(busy), 0);
    check("t3_state_error", 32'(state_dbg), 7);
    pulse_clear();
    check("t3_clear_state", 32'(state_dbg), 0);
    check("t3_clear_code", 32'(err_code), 0);
    check("t3_clear_flag", 32'(err_flag), 0);
    timeout_cycles = '0; hang[0] = 1'b0;

    // stage_error on stage 1 during its EXEC
    @(negedge clk);
    stage_mask = 2'b11; done_delay = '{3, 4}; hang[1] = 1'b1; err_cfg[1] = 1'b1;
    exp_q.push_back(IDX_W'(0));
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_err("t4a");
    check("t4a_err_code", 32'(err_code), 1);
    check("t4a_err_stage", 32'(err_stage), 1);
    check("t4a_start_low", 32'(stage_start), 0);
    check("t4a_pass_held", 32'(pass_count), 32'(exp_pass));
    pulse_clear();
    check("t4a_code_cleared", 32'(err_code), 0);
    check("t4a_stage_kept", 32'(err_stage), 1);

    // error and done together on stage 1: error wins
    hang[1] = 1'b0;
    exp_q.push_back(IDX_W'(0));
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_err("t4b");
    check("t4b_err_code", 32'(err_code), 1);
    check("t4b_err_stage", 32'(err_stage), 1);
    check("t4b_pass_held", 32'(pass_count), 32'(exp_pass));
    pulse_clear();
    err_cfg[1] = 1'b0;

    // continuous, enable dropped during stage 0 EXEC
    @(negedge clk);
    stage_mask = 2'b11; mode = 1'b1; done_delay = '{6, 3};
    exp_q.push_back(IDX_W'(0)); exp_q.push_back(IDX_W'(1));
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    wait_idle("t5");
    exp_pass++;
    #2;
    check("t5_pass_count", 32'(pass_count), 32'(exp_pass));
    check("t5_state_idle", 32'(state_dbg), 0);
    check("t5_sb_drained", 32'(exp_q.size()), 0);

    // reset asserted during ACK_WAIT
    @(negedge clk);
    stage_mask = 2'b01; mode = 1'b0; done_delay = '{3, 3}; ack_hold[0] = 8;
    exp_q.push_back(IDX_W'(0));
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    n = 0;
    while (!stage_ack[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("t6_in_ack_wait", 32'(state_dbg), 5);
    #5 reset = 1'b0;
    #1;
    check("t6_async_start", 32'(stage_start), 0);
    check("t6_async_ack", 32'(stage_ack), 0);
    check("t6_async_busy", 32'(busy), 0);
    check("t6_async_state", 32'(state_dbg), 0);
    check("t6_async_pass", 32'(pass_count), 0);
    check("t6_async_err_stage", 32'(err_stage), 0);
    @(negedge clk);
    reset = 1'b1;
    ack_hold[0] = 1;
    exp_pass = 0;
    repeat (2) @(negedge clk);
    check("t6_state_after", 32'(state_dbg), 0);
    check("t6_pass_after", 32'(pass_count), 32'(exp_pass));
    check("t6_busy_after", 32'(busy), 0);

    #2;
    check("final_sb_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
